// File: rtl/dm_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: DM op codes and arbiter state codes.
package dm_port_arbiter_pkg;

    localparam logic [2:0] DM_w  = 3'd0;
    localparam logic [2:0] DM_h  = 3'd1;
    localparam logic [2:0] DM_hu = 3'd2;
    localparam logic [2:0] DM_b  = 3'd3;
    localparam logic [2:0] DM_bu = 3'd4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of both requester channels plus the data-memory side of the arbiter.
interface dm_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              r0_req, r0_we, r0_lock;
    logic [ADDR_W-1:0] r0_addr;
    logic [31:0]       r0_wdata;
    logic [2:0]        r0_op;
    logic              r1_req, r1_we, r1_lock;
    logic [ADDR_W-1:0] r1_addr;
    logic [31:0]       r1_wdata;
    logic [2:0]        r1_op;

    logic              r0_gnt, r1_gnt;
    logic              r0_rvalid, r1_rvalid;
    logic              r0_err, r1_err;
    logic [31:0]       rdata;

    logic [ADDR_W-1:0] dm_A;
    logic [31:0]       dm_WD;
    logic [2:0]        dm_op;
    logic              dm_WE;
    logic [31:0]       dm_DMout;

    modport slave (
        input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata, r0_op,
        input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_op,
        output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err, rdata,
        output dm_A, dm_WD, dm_op, dm_WE,
        input  dm_DMout
    );

    modport master (
        output r0_req, r0_we, r0_lock, r0_addr, r0_wdata, r0_op,
        output r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_op,
        input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err, rdata,
        input  dm_A, dm_WD, dm_op, dm_WE,
        output dm_DMout
    );

endinterface

// File: rtl/dm_align_check.sv
// Flags a DM access whose byte address is not aligned to the access size of its op.
module dm_align_check
    import dm_port_arbiter_pkg::*;
(
    input  logic [2:0] op,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);

    // Unknown op codes are treated as word accesses.
    always_comb begin
        misaligned = 1'b0;
        unique case (op)
            DM_h, DM_hu: misaligned = addr_lo[0];
            DM_b, DM_bu: misaligned = 1'b0;
            default:     misaligned = (addr_lo != 2'b00);
        endcase
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: round-robin/CPU-priority grant,
// bounded lock ownership, alignment check and a one-cycle registered response.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int CPU_PRIORITY = 1,
    parameter int MAX_LOCK     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    dm_port_arbiter_if.slave     bus
);

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    arb_state_e        state, state_n;
    logic              last_gnt, last_gnt_n;
    logic [7:0]        lock_cnt, lock_cnt_n;
    logic              fav_vld, fav_vld_n, fav_id, fav_id_n;
    logic              pick0, pick1, gnt_any;
    logic              sel_we, sel_lock, sel_mis;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_op;
    logic              vld0_p1, vld1_p1, err_p1;
    logic [31:0]       rdata_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            last_gnt <= 1'b1;
            lock_cnt <= '0;
            fav_vld  <= 1'b0;
            fav_id   <= 1'b0;
        end else begin
            state    <= state_n;
            last_gnt <= last_gnt_n;
            lock_cnt <= lock_cnt_n;
            fav_vld  <= fav_vld_n;
            fav_id   <= fav_id_n;
        end
    end

    // fav_* gives the non-owner the first contest after a lock hits MAX_LOCK.
    always_comb begin
        pick0      = 1'b0;
        pick1      = 1'b0;
        state_n    = state;
        last_gnt_n = last_gnt;
        lock_cnt_n = lock_cnt;
        fav_vld_n  = 1'b0;
        fav_id_n   = fav_id;
        unique case (state)
            ARB_IDLE: begin
                if (bus.r0_req && bus.r1_req) begin
                    if (fav_vld)                pick1 = fav_id;
                    else if (CPU_PRIORITY != 0) pick1 = 1'b0;
                    else                        pick1 = ~last_gnt;
                    pick0 = ~pick1;
                end else begin
                    pick0 = bus.r0_req;
                    pick1 = bus.r1_req;
                end
            end
            ARB_OWN0: pick0 = bus.r0_req;
            ARB_OWN1: pick1 = bus.r1_req;
            default:  ;
        endcase
        gnt_any  = pick0 | pick1;
        sel_lock = pick1 ? bus.r1_lock : bus.r0_lock;
        if (gnt_any) begin
            last_gnt_n = pick1;
            if (!sel_lock) begin
                state_n = ARB_IDLE;
            end else if (state == ARB_IDLE && MAX_LOCK > 1) begin
                state_n    = pick1 ? ARB_OWN1 : ARB_OWN0;
                lock_cnt_n = 8'd1;
            end else if (state != ARB_IDLE && (lock_cnt + 8'd1) < MAX_LOCK_C) begin
                lock_cnt_n = lock_cnt + 8'd1;
            end else begin
                state_n   = ARB_IDLE;
                fav_vld_n = 1'b1;
                fav_id_n  = ~pick1;
            end
        end else if (state != ARB_IDLE) begin
            state_n = ARB_IDLE;
        end
        if (state_n == ARB_IDLE) lock_cnt_n = '0;
    end

    assign sel_we    = pick1 ? bus.r1_we    : bus.r0_we;
    assign sel_addr  = pick1 ? bus.r1_addr  : bus.r0_addr;
    assign sel_wdata = pick1 ? bus.r1_wdata : bus.r0_wdata;
    assign sel_op    = pick1 ? bus.r1_op    : bus.r0_op;

    dm_align_check u_align (
        .op         (sel_op),
        .addr_lo    (sel_addr[1:0]),
        .misaligned (sel_mis)
    );

    assign bus.r0_gnt = pick0 & ~reset;
    assign bus.r1_gnt = pick1 & ~reset;
    assign bus.dm_A   = sel_addr;
    assign bus.dm_WD  = sel_wdata;
    assign bus.dm_op  = sel_op;
    assign bus.dm_WE  = gnt_any & sel_we & ~sel_mis & ~reset;

    // Stage p1: response registered at the grant edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld0_p1  <= 1'b0;
            vld1_p1  <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld0_p1 <= pick0;
            vld1_p1 <= pick1;
            if (gnt_any) begin
                err_p1 <= sel_mis;
                if (sel_mis)      rdata_p1 <= '0;
                else if (!sel_we) rdata_p1 <= bus.dm_DMout;
            end
        end
    end

    assign bus.r0_rvalid = vld0_p1;
    assign bus.r1_rvalid = vld1_p1;
    assign bus.r0_err    = vld0_p1 & err_p1;
    assign bus.r1_err    = vld1_p1 & err_p1;
    assign bus.rdata     = rdata_p1;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench: CPU-priority instance (u_prio) with a word memory model, round-robin instance (u_rr).
module tb_dm_port_arbiter;
    import dm_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    dm_port_arbiter_if #(.ADDR_W(32)) bp ();
    dm_port_arbiter_if #(.ADDR_W(32)) br ();

    dm_port_arbiter #(.ADDR_W(32), .CPU_PRIORITY(1), .MAX_LOCK(4)) u_prio (
        .clk   (clk),
        .reset (reset),
        .bus   (bp.slave)
    );

    dm_port_arbiter #(.ADDR_W(32), .CPU_PRIORITY(0), .MAX_LOCK(4)) u_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (br.slave)
    );

    always @(posedge clk) if (bp.dm_WE) mem[bp.dm_A[11:2]] <= bp.dm_WD;
    assign bp.dm_DMout = mem[bp.dm_A[11:2]];
    assign br.dm_DMout = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic p0(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] op);
        bp.r0_req = req; bp.r0_we = we; bp.r0_lock = lock;
        bp.r0_addr = addr; bp.r0_wdata = wd; bp.r0_op = op;
    endtask

    task automatic p1(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] op);
        bp.r1_req = req; bp.r1_we = we; bp.r1_lock = lock;
        bp.r1_addr = addr; bp.r1_wdata = wd; bp.r1_op = op;
    endtask

    task automatic rr(input logic req0, input logic req1, input logic lock1);
        br.r0_req = req0; br.r0_we = 1'b0; br.r0_lock = 1'b0;
        br.r0_addr = 32'h0; br.r0_wdata = 32'h0; br.r0_op = DM_w;
        br.r1_req = req1; br.r1_we = 1'b0; br.r1_lock = lock1;
        br.r1_addr = 32'h4; br.r1_wdata = 32'h0; br.r1_op = DM_w;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset = 1'b1;
        rr(1'b0, 1'b0, 1'b0);
        p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);
        p0(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, DM_w);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt0", 32'(bp.r0_gnt), 32'h0);
        chk("rst_dm_we", 32'(bp.dm_WE), 32'h0);
        chk("rst_rvalid0", 32'(bp.r0_rvalid), 32'h0);
        chk("rst_rvalid1", 32'(bp.r1_rvalid), 32'h0);
        chk("rst_err0", 32'(bp.r0_err), 32'h0);
        chk("rst_rdata", bp.rdata, 32'h0);

        // r0 word store, then r1 word load of the same address
        @(negedge clk); reset = 1'b0; #1;
        chk("st_gnt0", 32'(bp.r0_gnt), 32'h1);
        chk("st_gnt1", 32'(bp.r1_gnt), 32'h0);
        chk("st_dm_we", 32'(bp.dm_WE), 32'h1);
        chk("st_dm_a", bp.dm_A, 32'h10);
        chk("st_dm_wd", bp.dm_WD, 32'hDEADBEEF);
        @(negedge clk);
        p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);
        p1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, DM_w);
        #1;
        chk("st_ack_rvalid0", 32'(bp.r0_rvalid), 32'h1);
        chk("st_ack_err0", 32'(bp.r0_err), 32'h0);
        chk("st_ack_rdata", bp.rdata, 32'h0);
        chk("ld_gnt1", 32'(bp.r1_gnt), 32'h1);
        chk("ld_gnt0", 32'(bp.r0_gnt), 32'h0);
        chk("ld_dm_we", 32'(bp.dm_WE), 32'h0);
        @(negedge clk);
        p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);
        #1;
        chk("ld_rvalid1", 32'(bp.r1_rvalid), 32'h1);
        chk("ld_rvalid0", 32'(bp.r0_rvalid), 32'h0);
        chk("ld_err1", 32'(bp.r1_err), 32'h0);
        chk("ld_rdata", bp.rdata, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("ld_rvalid1_drop", 32'(bp.r1_rvalid), 32'h0);

        // CPU priority: r0 wins every contest
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            p0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);
            p1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, DM_w);
            #1;
            chk("prio_gnt0", 32'(bp.r0_gnt), 32'h1);
            chk("prio_gnt1", 32'(bp.r1_gnt), 32'h0);
        end
        @(negedge clk);
        p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);
        p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);

        // Round robin: 0,1,0,1,0
        rr(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk("rr_gnt0", 32'(br.r0_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_gnt1", 32'(br.r1_gnt), (i % 2 == 1) ? 32'h1 : 32'h0);
        end

        // r1 locks 3 beats on the round-robin instance, r0 held off
        @(negedge clk); rr(1'b1, 1'b1, 1'b1); #1;
        chk("lk3_b1_gnt1", 32'(br.r1_gnt), 32'h1);
        chk("lk3_b1_gnt0", 32'(br.r0_gnt), 32'h0);
        @(negedge clk); #1;
        chk("lk3_b2_gnt1", 32'(br.r1_gnt), 32'h1);
        chk("lk3_b2_gnt0", 32'(br.r0_gnt), 32'h0);
        @(negedge clk); rr(1'b1, 1'b1, 1'b0); #1;
        chk("lk3_b3_gnt1", 32'(br.r1_gnt), 32'h1);
        chk("lk3_b3_gnt0", 32'(br.r0_gnt), 32'h0);
        @(negedge clk); rr(1'b1, 1'b0, 1'b0); #1;
        chk("lk3_b4_gnt0", 32'(br.r0_gnt), 32'h1);
        @(negedge clk); rr(1'b0, 1'b0, 1'b0);

        // r1 holds lock continuously; MAX_LOCK=4 releases it to r0
        p1(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, DM_w);
        #1;
        chk("ml1_b1_gnt1", 32'(bp.r1_gnt), 32'h1);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            p0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);
            #1;
            chk("ml1_gnt1", 32'(bp.r1_gnt), 32'h1);
            chk("ml1_gnt0", 32'(bp.r0_gnt), 32'h0);
            if (i == 2) chk("ml1_rdata", bp.rdata, 32'hDEADBEEF);
        end
        @(negedge clk); #1;
        chk("ml1_rel_gnt0", 32'(bp.r0_gnt), 32'h1);
        chk("ml1_rel_gnt1", 32'(bp.r1_gnt), 32'h0);
        @(negedge clk);
        p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);
        p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);

        // r0 holds lock continuously; on expiry r1 wins despite CPU priority
        @(negedge clk);
        p0(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, DM_w);
        p1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, DM_w);
        for (int i = 1; i <= 4; i++) begin
            if (i != 1) @(negedge clk);
            #1;
            chk("ml0_gnt0", 32'(bp.r0_gnt), 32'h1);
            chk("ml0_gnt1", 32'(bp.r1_gnt), 32'h0);
        end
        @(negedge clk); #1;
        chk("ml0_rel_gnt1", 32'(bp.r1_gnt), 32'h1);
        chk("ml0_rel_gnt0", 32'(bp.r0_gnt), 32'h0);
        @(negedge clk);
        p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);
        p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);

        // Alignment: misaligned half store, byte load, misaligned word load
        @(negedge clk);
        p0(1'b1, 1'b1, 1'b0, 32'h13, 32'h00001234, DM_h);
        #1;
        chk("mis_h_gnt0", 32'(bp.r0_gnt), 32'h1);
        chk("mis_h_dm_we", 32'(bp.dm_WE), 32'h0);
        @(negedge clk);
        p0(1'b1, 1'b0, 1'b0, 32'h13, 32'h0, DM_b);
        #1;
        chk("mis_h_rvalid0", 32'(bp.r0_rvalid), 32'h1);
        chk("mis_h_err0", 32'(bp.r0_err), 32'h1);
        chk("mis_h_rdata", bp.rdata, 32'h0);
        @(negedge clk);
        p0(1'b1, 1'b0, 1'b0, 32'h12, 32'h0, DM_w);
        #1;
        chk("ld_b_rvalid0", 32'(bp.r0_rvalid), 32'h1);
        chk("ld_b_err0", 32'(bp.r0_err), 32'h0);
        chk("ld_b_rdata", bp.rdata, 32'hDEADBEEF);
        @(negedge clk);
        p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);
        #1;
        chk("mis_w_rvalid0", 32'(bp.r0_rvalid), 32'h1);
        chk("mis_w_err0", 32'(bp.r0_err), 32'h1);
        chk("mis_w_rdata", bp.rdata, 32'h0);

        // Reset while r1 owns the port
        @(negedge clk);
        p1(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, DM_w);
        #1;
        chk("rs_b1_gnt1", 32'(bp.r1_gnt), 32'h1);
        @(negedge clk);
        p0(1'b1, 1'b1, 1'b0, 32'h20, 32'h55AA55AA, DM_w);
        #1;
        chk("rs_b2_gnt1", 32'(bp.r1_gnt), 32'h1);
        chk("rs_b2_gnt0", 32'(bp.r0_gnt), 32'h0);
        chk("rs_b2_rvalid1", 32'(bp.r1_rvalid), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rs_gnt0", 32'(bp.r0_gnt), 32'h0);
        chk("rs_gnt1", 32'(bp.r1_gnt), 32'h0);
        chk("rs_rvalid1", 32'(bp.r1_rvalid), 32'h0);
        chk("rs_err1", 32'(bp.r1_err), 32'h0);
        chk("rs_dm_we", 32'(bp.dm_WE), 32'h0);
        chk("rs_rdata", bp.rdata, 32'h0);
        @(negedge clk); reset = 1'b0; #1;
        chk("rs_rel_gnt0", 32'(bp.r0_gnt), 32'h1);
        chk("rs_rel_gnt1", 32'(bp.r1_gnt), 32'h0);
        chk("rs_rel_rvalid1", 32'(bp.r1_rvalid), 32'h0);
        @(negedge clk);
        p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);
        p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, DM_w);
        #1;
        chk("rs_rel_rvalid0", 32'(bp.r0_rvalid), 32'h1);
        chk("rs_rel_mem", mem[8], 32'h55AA55AA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port (word-indexed, A[11:2], ops DM_w/h/hu/b/bu) between two requesters.
- Requester 0 is the CPU M-stage load/store path; requester 1 is a DMA/debug master.
- Grants one access per cycle, with round-robin fairness and an optional lock for multi-beat sequences.
- Checks alignment, registers read data, and drives the DM write-enable, address, write data and op.

Parameters:
- ADDR_W, 32, width of requester and DM addresses.
- CPU_PRIORITY, 1, 1 = requester 0 wins every contested IDLE cycle; 0 = pure round-robin.
- MAX_LOCK, 16, maximum consecutive beats a locked owner may hold the port (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- r0_req, r1_req  in  1  access request, held until granted
- r0_we, r1_we  in  1  1 = store, 0 = load
- r0_lock, r1_lock  in  1  keep ownership after this beat
- r0_addr, r1_addr  in  ADDR_W  byte address
- r0_wdata, r1_wdata  in  32  store data
- r0_op, r1_op  in  3  DM op code (const.v encoding)
- r0_gnt, r1_gnt  out  1  beat accepted this cycle (combinational)
- r0_rvalid, r1_rvalid  out  1  load data / error response valid
- r0_err, r1_err  out  1  misaligned access flag, qualified by rvalid
- rdata  out  32  registered load data, shared by both requesters
- dm_A  out  ADDR_W  to DM A
- dm_WD  out  32  to DM WD
- dm_op  out  3  to DM DM_op
- dm_WE  out  1  to DM WE
- dm_DMout  in  32  from DM DMout (combinational read)

Behaviour:
- Reset (async): state=IDLE, last_gnt=1 (requester 0 wins the first contest), lock_cnt=0. All gnt, rvalid, err, dm_WE = 0; rdata = 0.
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: the owner holds the port through lock.
- IDLE arbitration:
  - Single requester is granted.
  - Both requesting: requester 0 if CPU_PRIORITY=1, else the requester that is not last_gnt.
  - last_gnt updates on every grant.
- Granted beat with lock=1: enter OWNx, lock_cnt=1.
- OWNx:
  - Only x may be granted; the other requester is held off.
  - Granted beat with lock=0, owner req low, or lock_cnt reaching MAX_LOCK: return to IDLE.
  - When the lock expires at MAX_LOCK, the other requester gets the next cycle if it is requesting.
- At most one gnt per cycle. The DM mux follows the granted requester; with no grant, dm_WE=0 and dm_op=r0_op.
- Alignment check:
  - Misaligned: DM_w/none with addr[1:0]!=0, or DM_h/DM_hu with addr[0]!=0.
  - A misaligned beat is still granted, but dm_WE is forced to 0.
  - Next cycle: rvalid=1 and err=1 for that requester, rdata=0.
- Load (we=0, aligned): rdata<=dm_DMout at the grant edge; rvalid=1 in the following cycle only, err=0. Latency is 1 cycle.
- Store (we=1, aligned): dm_WE=1 in the grant cycle and the memory commits at that edge. rvalid pulses the next cycle (store acknowledge), rdata is unchanged.
- Reset asserted mid-sequence: lock abandoned, state=IDLE immediately, no pending rvalid.
- gnt asserts in the same cycle as req. A requester must hold its request fields stable until gnt.

Decomposition:
- Shared constants (const.v): DM_w, DM_h, DM_hu, DM_b, DM_bu encodings; ARB_IDLE, ARB_OWN0, ARB_OWN1 state codes.
- One natural sub-module, dm_align_check: combinational op+addr -> misaligned flag, reusable by the exception logic.

Test Plan:
- r0 store DM_w addr 0x10 data 0xDEADBEEF, then r1 load DM_w 0x10 -> r1_rvalid one cycle after r1_gnt, rdata=0xDEADBEEF.
- Both request every cycle, CPU_PRIORITY=0, no lock -> grants alternate 0,1,0,1; with CPU_PRIORITY=1 only r0 is granted.
- r1 asserts lock for 3 beats while r0 requests -> r0_gnt low for those 3 cycles, r0 granted on the 4th.
- r1 holds lock continuously with MAX_LOCK=4 -> r1 released after 4 beats, r0 granted next cycle.
- r0 store DM_h addr 0x13 -> dm_WE stays 0, r0_rvalid=1 with r0_err=1 next cycle; r0 load DM_b 0x13 -> err=0.
- Reset asserted while in OWN1 -> all outputs 0 asynchronously; after release, a contest grants r0 first.
